// File: rtl/des_iter_core.sv
// des_iter_core: iterative single-DES engine running ROUNDS_PER_CYCLE Feistel rounds per clock,
// with the C/D key schedule rotated on the fly (left for encrypt, right for decrypt).
module des_iter_core #(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mode,
  input  logic [1:64] message,
  input  logic [1:64] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:64] result,
  output logic        busy
);
  localparam int NUM_ITER = 16 / ROUNDS_PER_CYCLE;
  if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 &&
      ROUNDS_PER_CYCLE != 8 && ROUNDS_PER_CYCLE != 16) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end
  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2,60,52,44,36,28,20,12,4,62,54,46,38,30,22,14,6,
    64,56,48,40,32,24,16,8,57,49,41,33,25,17,9,1,59,51,43,35,27,19,11,3,61,53,45,37,29,21,13,5,63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32,39,7,47,15,55,23,63,31,38,6,46,14,54,22,62,30,
    37,5,45,13,53,21,61,29,36,4,44,12,52,20,60,28,35,3,43,11,51,19,59,27,34,2,42,10,50,18,58,26,33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5,4,5,6,7,8,9,8,9,10,11,12,13,12,13,14,15,16,17,
    16,17,18,19,20,21,20,21,22,23,24,25,24,25,26,27,28,29,28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
  localparam int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  localparam int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  // Each S-box is stored row-major: index = {b1,b6,b2,b3,b4,b5}.
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};
  function automatic logic [1:64] ip(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[IP_T[i]];
    return y;
  endfunction
  function automatic logic [1:64] fp(input logic [1:64] x);
    logic [1:64] y;
    for (int i = 0; i < 64; i++) y[i+1] = x[FP_T[i]];
    return y;
  endfunction
  function automatic logic [1:56] pc1(input logic [1:64] x);
    logic [1:56] y;
    for (int i = 0; i < 56; i++) y[i+1] = x[PC1_T[i]];
    return y;
  endfunction
  function automatic logic [1:48] pc2(input logic [1:56] x);
    logic [1:48] y;
    for (int i = 0; i < 48; i++) y[i+1] = x[PC2_T[i]];
    return y;
  endfunction
  function automatic logic [1:32] f(input logic [1:32] x, input logic [1:48] k);
    logic [1:48] e;
    logic [1:32] s, y;
    logic [5:0] b;
    for (int i = 0; i < 48; i++) e[i+1] = x[E_T[i]];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b = e[6*j+1 +: 6];
      s[4*j+1 +: 4] = 4'(SBOX[j][{b[5], b[0], b[4:1]}]);
    end
    for (int i = 0; i < 32; i++) y[i+1] = s[P_T[i]];
    return y;
  endfunction
  // Decrypt walks the schedule backwards: no rotation before round 1, otherwise mirror of encrypt.
  function automatic logic [1:0] shamt(input logic dec, input logic [4:0] k);
    return (dec && k == 0) ? 2'd0 : (k == 0 || k == 1 || k == 8 || k == 15) ? 2'd1 : 2'd2;
  endfunction
  function automatic logic [1:28] rot(input logic [1:28] x, input logic dec, input logic [1:0] sh);
    return sh == 2'd0 ? x :
           dec ? (sh == 2'd1 ? {x[28], x[1:27]} : {x[27:28], x[1:26]}) :
                 (sh == 2'd1 ? {x[2:28], x[1]} : {x[3:28], x[1:2]});
  endfunction
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_n;
  logic md;
  logic [1:32] l, r, nl, nr, t;
  logic [1:28] c, d, nc, dn;
  logic [4:0] rnd, k;
  logic last;
  assign in_ready  = st == IDLE;
  assign out_valid = st == DONE;
  assign busy      = st != IDLE;
  assign last      = rnd == 5'((NUM_ITER - 1) * ROUNDS_PER_CYCLE);
  always_comb begin
    st_n = (st == IDLE && in_valid) ? RUN :
           (st == RUN && last)      ? DONE :
           (st == DONE && out_ready) ? IDLE : st;
  end
  always_comb begin
    nl = l;
    nr = r;
    nc = c;
    dn = d;
    t  = '0;
    k  = '0;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      k  = rnd + 5'(j);
      nc = rot(nc, md, shamt(md, k));
      dn = rot(dn, md, shamt(md, k));
      t  = nr;
      nr = nl ^ f(nr, pc2({nc, dn}));
      nl = t;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= IDLE;
    else st <= st_n;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md     <= 1'b0;
      l      <= '0;
      r      <= '0;
      c      <= '0;
      d      <= '0;
      rnd    <= '0;
      result <= '0;
    end else if (st == IDLE && in_valid) begin
      md     <= mode;
      {l, r} <= ip(message);
      {c, d} <= pc1(key);
      rnd    <= '0;
    end else if (st == RUN) begin
      l   <= nl;
      r   <= nr;
      c   <= nc;
      d   <= dn;
      rnd <= rnd + 5'(ROUNDS_PER_CYCLE);
      if (last) result <= fp({nr, nl});
    end
  end
endmodule

// File: tb/tb_des_iter_core.sv
// tb_des_iter_core: scoreboard bench driving five cores (1,2,4,8,16 rounds per clock) with known DES vectors.
module tb_des_iter_core;
  logic clk = 1'b0;
  logic rst, ordy;
  logic [4:0] iv, md, ir, ov, bz;
  logic [63:0] msg [5];
  logic [63:0] key [5];
  logic [63:0] res [5];
  logic [63:0] exp_q [5][$];
  int acc_q [5][$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    des_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .mode(md[g]),
      .message(msg[g]), .key(key[g]), .out_valid(ov[g]), .out_ready(ordy),
      .result(res[g]), .busy(bz[g]));
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask
  task automatic fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s", nm);
  endtask
  function automatic bit pending();
    for (int k = 0; k < 5; k++) if (exp_q[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic monitor();
    logic [4:0] ovd = '0;
    forever begin
      @(negedge clk);
      if (rst) ovd = '0;
      else begin
        for (int k = 0; k < 5; k++) begin
          if (iv[k] && ir[k]) acc_q[k].push_back(cyc);
          if (ov[k] && !ovd[k]) begin
            if (acc_q[k].size() == 0) fail($sformatf("latency_r%0d no accept seen", 1 << k));
            else chk($sformatf("latency_r%0d", 1 << k), 64'(cyc - acc_q[k].pop_front()), 64'(16 / (1 << k) + 1));
          end
          if (ov[k]) begin
            chk($sformatf("in_ready_in_done_r%0d", 1 << k), 64'(ir[k]), 64'h0);
            if (exp_q[k].size() == 0) fail($sformatf("unexpected_out_r%0d result=%h", 1 << k, res[k]));
            else begin
              chk($sformatf("result_r%0d", 1 << k), res[k], exp_q[k][0]);
              if (ordy) void'(exp_q[k].pop_front());
            end
          end
        end
        ovd = ov;
      end
    end
  endtask
  task automatic send(input logic [4:0] m, input logic dm, input logic [63:0] mg, input logic [63:0] ky,
                      input logic [63:0] ex);
    int n = 0;
    while ((ir & m) != m && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((ir & m) != m) begin
      fail($sformatf("send_wait in_ready=%b need=%b", ir, m));
      return;
    end
    for (int k = 0; k < 5; k++)
      if (m[k]) begin
        md[k] = dm;
        msg[k] = mg;
        key[k] = ky;
        iv[k] = 1'b1;
        exp_q[k].push_back(ex);
      end
    @(posedge clk);
    #1;
    iv = iv & ~m;
  endtask
  task automatic drain();
    int n = 0;
    while (pending() && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (pending()) fail("drain timeout");
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int t_a, n;
    rst = 1'b1;
    ordy = 1'b1;
    iv = '0;
    md = '0;
    for (int k = 0; k < 5; k++) begin
      msg[k] = '0;
      key[k] = '0;
    end
    fork
      monitor();
    join_none
    @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir), 64'h1f);
    chk("rst_out_valid", 64'(ov), 64'h0);
    chk("rst_busy", 64'(bz), 64'h0);
    for (int k = 0; k < 5; k++) chk("rst_result", res[k], 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(5'h1f, 1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    drain();
    send(5'h1f, 1'b1, 64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF);
    drain();
    send(5'h1f, 1'b1, 64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787);
    drain();
    send(5'h1f, 1'b0, 64'h8787878787878787, 64'h0E329232EA6D0D73, 64'h0000000000000000);
    drain();
    // Backpressure: results must hold, new requests must be ignored.
    ordy = 1'b0;
    send(5'h1f, 1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    n = 0;
    while (!ov[0] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ov[0]) fail("bp out_valid timeout");
    for (int k = 0; k < 5; k++) begin
      msg[k] = 64'hDEADBEEFCAFEF00D;
      md[k] = 1'b1;
    end
    iv = 5'h1f;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 64'(ir), 64'h0);
      chk("bp_busy", 64'(bz), 64'h1f);
    end
    iv = '0;
    ordy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 64'(ir), 64'h1f);
    drain();
    // Abort mid-RUN at round 8 of the single-round core.
    ordy = 1'b0;
    send(5'h1f, 1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 64'(ov), 64'h0);
    chk("abort_in_ready", 64'(ir), 64'h1f);
    chk("abort_busy", 64'(bz), 64'h0);
    for (int k = 0; k < 5; k++) begin
      chk("abort_result", res[k], 64'h0);
      exp_q[k].delete();
      acc_q[k].delete();
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    ordy = 1'b1;
    send(5'h1f, 1'b0, 64'h8787878787878787, 64'h0E329232EA6D0D73, 64'h0000000000000000);
    drain();
    send(5'h1f, 1'b0, 64'h0123456789ABCDEF, 64'h133457799BBCDFF1, 64'h85E813540F0AB405);
    drain();
    // Back-to-back on the single-round core with in_valid held high.
    md[0] = 1'b0;
    msg[0] = 64'h0123456789ABCDEF;
    key[0] = 64'h133457799BBCDFF1;
    iv[0] = 1'b1;
    exp_q[0].push_back(64'h85E813540F0AB405);
    @(posedge clk);
    #1;
    t_a = cyc;
    md[0] = 1'b1;
    msg[0] = 64'h85E813540F0AB405;
    exp_q[0].push_back(64'h0123456789ABCDEF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ir[0] && n < 100);
    if (!ir[0]) fail("b2b in_ready timeout");
    @(posedge clk);
    #1;
    chk("b2b_spacing", 64'(cyc - t_a), 64'd18);
    iv[0] = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
